mult_control: RTL and testbench

//  Sequencer for the 8-bit add-shift multiplier datapath (A/B/X registers, add/sub unit, shifter).

---
 rtl/mult_pkg.sv | 5 +
 rtl/input_sync.sv | 21 ++
 rtl/mult_control.sv | 71 +++++++
 tb/tb_mult_control.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: shared state encoding and default width for the multiplier sequencer
package mult_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, WAITL, CLRA, ADD, SHIFT, HOLD} ctrl_state_t;
    localparam int MULT_N_BITS = 8;
endpackage

// File: rtl/input_sync.sv
// input_sync: multi-flop synchroniser for one asynchronous level input
module input_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic Clk,
    input  logic Reset,
    input  logic d,
    output logic q
);
    logic [SYNC_STAGES-1:0] ff;
    // shift the raw level through the chain, cleared asynchronously
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            ff <= '0;
        end else begin
            ff[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) ff[i] <= ff[i-1];
        end
    end
    assign q = ff[SYNC_STAGES-1];
endmodule

// File: rtl/mult_control.sv
// mult_control: sequencer issuing one-cycle strobes to the add-shift multiplier datapath
module mult_control
    import mult_pkg::*;
#(
    parameter int N_BITS      = MULT_N_BITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      Run,
    input  logic                      ClearA_LoadB,
    input  logic                      M,
    output logic                      Clr_Ld,
    output logic                      Clear_A,
    output logic                      Add,
    output logic                      Sub,
    output logic                      Shift,
    output logic                      Busy,
    output logic                      Done,
    output logic [$clog2(N_BITS):0]   Count
);
    localparam int CW = $clog2(N_BITS) + 1;
    localparam logic [CW-1:0] LAST = CW'(N_BITS - 1);
    ctrl_state_t state, state_nx;
    logic run_s, ld_s, last;
    input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_run_sync (
        .Clk   (Clk),
        .Reset (Reset),
        .d     (Run),
        .q     (run_s)
    );
    input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ld_sync (
        .Clk   (Clk),
        .Reset (Reset),
        .d     (ClearA_LoadB),
        .q     (ld_s)
    );
    // the final iteration subtracts because the multiplier MSB carries negative weight
    assign last = Count == LAST;
    // next-state: Run wins over load; WAITL and HOLD wait for release so one press acts once
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = run_s ? CLRA : ld_s ? LOAD : IDLE;
            LOAD:    state_nx = WAITL;
            WAITL:   state_nx = ld_s ? WAITL : IDLE;
            CLRA:    state_nx = ADD;
            ADD:     state_nx = SHIFT;
            SHIFT:   state_nx = last ? HOLD : ADD;
            HOLD:    state_nx = run_s ? HOLD : IDLE;
            default: state_nx = IDLE;
        endcase
    end
    // state register and iteration counter; counter restarts on CLRA and stays at N_BITS in HOLD
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            Count <= '0;
        end else begin
            state <= state_nx;
            Count <= state == CLRA ? '0 : state == SHIFT ? Count + CW'(1) : Count;
        end
    end
    assign Clr_Ld  = state == LOAD;
    assign Clear_A = state == CLRA;
    assign Add     = state == ADD && M && !last;
    assign Sub     = state == ADD && M && last;
    assign Shift   = state == SHIFT;
    assign Busy    = state inside {CLRA, ADD, SHIFT};
    assign Done    = state == HOLD;
endmodule

// File: tb/tb_mult_control.sv
// tb_mult_control: randomized check of the multiplier sequencer against a cycle-schedule model
module tb_mult_control;
    localparam int N  = 8;
    localparam int S  = 2;
    localparam int CW = 4;
    localparam int MD_IDLE = 0, MD_LOAD = 1, MD_WREL = 2, MD_RUN = 3, MD_HOLD = 4;
    logic Clk = 0, Reset = 0, Run = 0, ClearA_LoadB = 0, M;
    logic Clr_Ld, Clear_A, Add, Sub, Shift, Busy, Done;
    logic [CW-1:0] Count;
    int checks = 0, fails = 0;
    logic [7:0] b_reg = '0, s_val = '0;
    int mode = MD_IDLE, step = 0, mcnt = 0, cyc = 0;
    bit rp[S], lp[S];
    int n_clr, n_cla, n_add, n_sub, n_sh, n_busy, first_clr, sub_at, rise;
    logic [15:0] add_mask;
    logic [10:0] exp_v, act_v;
    logic run_ph, add_ph;
    int it;

    mult_control #(.N_BITS(N), .SYNC_STAGES(S)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Run          (Run),
        .ClearA_LoadB (ClearA_LoadB),
        .M            (M),
        .Clr_Ld       (Clr_Ld),
        .Clear_A      (Clear_A),
        .Add          (Add),
        .Sub          (Sub),
        .Shift        (Shift),
        .Busy         (Busy),
        .Done         (Done),
        .Count        (Count)
    );

    always #5 Clk = ~Clk;

    // minimal B register so M follows the multiplier bits the way the datapath would present them
    assign M = b_reg[0];
    always @(posedge Clk) begin
        if (Clr_Ld) b_reg <= s_val;
        else if (Shift) b_reg <= b_reg >> 1;
    end

    // model: a run is a 2N+1 step schedule (step 0 clear, odd steps add, even steps shift)
    always @(posedge Clk) begin
        cyc++;
        if (!Reset) begin
            mode = MD_IDLE; step = 0; mcnt = 0;
            for (int i = 0; i < S; i++) begin rp[i] = 0; lp[i] = 0; end
        end else begin
            case (mode)
                MD_IDLE: if (rp[S-1]) begin mode = MD_RUN; step = 0; end else if (lp[S-1]) mode = MD_LOAD;
                MD_LOAD: mode = MD_WREL;
                MD_WREL: if (!lp[S-1]) mode = MD_IDLE;
                MD_RUN: begin
                    if (step == 0) mcnt = 0; else if (step % 2 == 0) mcnt++;
                    if (step == 2 * N) mode = MD_HOLD; else step++;
                end
                MD_HOLD: if (!rp[S-1]) mode = MD_IDLE;
                default: ;
            endcase
            for (int i = S - 1; i > 0; i--) begin rp[i] = rp[i-1]; lp[i] = lp[i-1]; end
            rp[0] = Run; lp[0] = ClearA_LoadB;
        end
        #1;
        run_ph = mode == MD_RUN;
        add_ph = run_ph && step % 2 == 1;
        it = step / 2;
        exp_v = {mode == MD_LOAD, run_ph && step == 0, add_ph && M && it < N - 1,
                 add_ph && M && it == N - 1, run_ph && step > 0 && step % 2 == 0,
                 run_ph, mode == MD_HOLD, CW'(mcnt)};
        act_v = {Clr_Ld, Clear_A, Add, Sub, Shift, Busy, Done, Count};
        checks++;
        if (act_v !== exp_v) begin
            fails++;
            $display("FAIL cycle %0d outputs {clr_ld,clear_a,add,sub,shift,busy,done,count} got %b expected %b",
                     cyc, act_v, exp_v);
        end
        if (Clr_Ld) begin n_clr++; if (first_clr < 0) first_clr = cyc; end
        if (Clear_A) n_cla++;
        if (Add) begin n_add++; add_mask[Count] = 1'b1; end
        if (Sub) begin n_sub++; sub_at = Count; end
        if (Shift) n_sh++;
        if (Busy) n_busy++;
    end

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got %0d expected %0d", nm, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic clear_tally();
        n_clr = 0; n_cla = 0; n_add = 0; n_sub = 0; n_sh = 0; n_busy = 0;
        first_clr = -1; sub_at = -1; add_mask = '0;
    endtask

    task automatic wait_done(input int lim);
        for (int i = 0; i < lim; i++) begin
            if (Done) return;
            @(negedge Clk);
        end
        chk("done_timeout", int'(Done), 1);
    endtask

    task automatic load(input logic [7:0] v);
        s_val = v;
        ClearA_LoadB = 1;
        tick(6);
        ClearA_LoadB = 0;
        tick(4);
    endtask

    task automatic release_run();
        Run = 0;
        tick(2);
        chk("done_before_release_seen", int'(Done), 1);
        tick(1);
        chk("done_after_release", int'(Done), 0);
    endtask

    initial begin
        clear_tally();
        tick(3);
        chk("reset_outputs", int'({Clr_Ld, Clear_A, Add, Sub, Shift, Busy, Done, Count}), 0);
        Reset = 1;
        tick(2);
        // single load pulse with 2+1 latency
        clear_tally();
        s_val = 8'hFF;
        ClearA_LoadB = 1;
        rise = cyc;
        tick(10);
        chk("load_pulses", n_clr, 1);
        chk("load_latency", first_clr - rise, 3);
        ClearA_LoadB = 0;
        tick(4);
        clear_tally();
        ClearA_LoadB = 1;
        tick(3);
        ClearA_LoadB = 0;
        tick(5);
        chk("reload_pulses", n_clr, 1);
        // all ones multiplier
        clear_tally();
        Run = 1;
        wait_done(40);
        chk("ones_clear_a", n_cla, 1);
        chk("ones_add", n_add, 7);
        chk("ones_add_mask", int'(add_mask), 16'h007F);
        chk("ones_sub", n_sub, 1);
        chk("ones_sub_at", sub_at, 7);
        chk("ones_shift", n_sh, 8);
        chk("ones_busy", n_busy, 17);
        chk("ones_count", int'(Count), 8);
        tick(6);
        chk("done_held", int'(Done), 1);
        release_run();
        tick(3);
        // zero multiplier
        load(8'h00);
        clear_tally();
        Run = 1;
        wait_done(40);
        chk("zero_addsub", n_add + n_sub, 0);
        chk("zero_shift", n_sh, 8);
        chk("zero_busy", n_busy, 17);
        release_run();
        tick(3);
        // B = 05
        load(8'h05);
        clear_tally();
        Run = 1;
        wait_done(40);
        chk("b05_add_mask", int'(add_mask), 16'h0005);
        chk("b05_sub", n_sub, 0);
        release_run();
        tick(3);
        // reset mid-run
        load(8'hFF);
        Run = 1;
        tick(6);
        Reset = 0;
        #1;
        chk("abort_outputs", int'({Clr_Ld, Clear_A, Add, Sub, Shift, Busy, Done, Count}), 0);
        @(negedge Clk);
        Run = 0;
        tick(2);
        clear_tally();
        Reset = 1;
        tick(10);
        chk("abort_idle_busy", n_busy, 0);
        chk("abort_idle_load", n_clr, 0);
        // simultaneous Run and load, load toggled mid-run
        clear_tally();
        Run = 1;
        ClearA_LoadB = 1;
        tick(6);
        ClearA_LoadB = 0;
        tick(3);
        ClearA_LoadB = 1;
        tick(2);
        ClearA_LoadB = 0;
        wait_done(40);
        tick(2);
        chk("both_clear_a", n_cla, 1);
        chk("both_no_load", n_clr, 0);
        release_run();
        tick(3);
        // randomized traffic: loads, presses during WAITL, load noise during runs
        for (int k = 0; k < 10; k++) begin
            s_val = 8'($urandom);
            ClearA_LoadB = 1;
            tick($urandom_range(1, 8));
            if ($urandom_range(0, 1) == 1) begin Run = 1; tick($urandom_range(1, 4)); end
            ClearA_LoadB = 0;
            Run = 1;
            for (int j = 0; j < 20; j++) begin
                ClearA_LoadB = 1'($urandom_range(0, 1));
                tick(1);
            end
            ClearA_LoadB = 0;
            wait_done(60);
            tick($urandom_range(0, 5));
            Run = 0;
            tick($urandom_range(3, 8));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule
